// File: rtl/common_vl_pack.sv
// common_vl_pack: shared vl_rec record type, data width and transmit state enum.
package common_vl_pack;
    localparam int VL_DATA_W = 32;
    typedef struct packed {
        logic                 vl_bit;
        logic [7:0]           vl_seq;
        logic [VL_DATA_W-1:0] vl_data;
    } vl_rec;
    typedef enum logic {IDLE, HOLD} vl_tx_state_e;
endpackage

// File: rtl/vl_sync_fifo.sv
// vl_sync_fifo: synchronous FIFO with wrap-bit pointers and a combinational head.
module vl_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = wp == rp;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/vl_rec_sender.sv
// vl_rec_sender: buffers payload words and emits them as vl_rec records,
// one vl_bit toggle per record, with a minimum idle gap between records.
module vl_rec_sender
    import common_vl_pack::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VL_DATA_W-1:0] in_data,
    input  logic                 enable,
    output vl_rec                data_sent,
    output logic                 busy,
    output logic [15:0]          sent_count
);
    localparam int GW = $clog2(GAP + 2);
    vl_tx_state_e state, state_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [7:0] seq, seq_n;
    logic [15:0] cnt_n;
    vl_rec rec_n;
    logic [VL_DATA_W-1:0] head;
    logic full, empty, emit;
    vl_sync_fifo #(.WIDTH(VL_DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(in_valid && in_ready), .pop(emit),
        .wdata(in_data), .rdata(head), .full(full), .empty(empty)
    );
    // in_ready is forced low during reset since occupancy is not yet known
    assign in_ready = !full && !reset;
    assign emit     = enable && !empty && (state == IDLE || (state == HOLD && gap_cnt == '0));
    assign busy     = !empty || (state == HOLD && gap_cnt != '0);
    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        seq_n   = seq;
        cnt_n   = sent_count;
        rec_n   = data_sent;
        if (emit) begin
            state_n = HOLD;
            gap_n   = GW'(GAP);
            seq_n   = seq + 8'd1;
            cnt_n   = sent_count + {15'd0, sent_count != 16'hFFFF};
            rec_n   = '{vl_bit: ~data_sent.vl_bit, vl_seq: seq, vl_data: head};
        end else if (state == HOLD) begin
            gap_n   = gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt;
            state_n = gap_cnt != '0 ? HOLD : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            seq        <= '0;
            sent_count <= '0;
            data_sent  <= '0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_n;
            seq        <= seq_n;
            sent_count <= cnt_n;
            data_sent  <= rec_n;
        end
    end
endmodule

// File: doc/vl_rec_sender.md
Name: vl_rec_sender

Overview:
Transmit end of the vl_rec record interface. The block accepts payload words on a valid/ready input and buffers them in a small FIFO. It emits one vl_rec record at a time on data_sent. Each new record is signalled by a toggle of data_sent.vl_bit, so a consumer that triggers on a change of vl_bit sees exactly one event per record. A programmable minimum gap between records paces the output for slow consumers.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
GAP, 3, idle clock edges enforced after each emitted record; 0 allowed

Ports:
clk  input  1  sole clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  payload word offered
in_ready  output  1  FIFO can accept; transfer occurs when in_valid && in_ready
in_data  input  VL_DATA_W  payload word
enable  input  1  permits emission; FIFO accepts data regardless of enable
data_sent  output  vl_rec  registered output record
busy  output  1  FIFO non-empty or gap still running
sent_count  output  16  records emitted since reset; saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high): FIFO emptied and contents discarded, state=IDLE, gap_cnt=0, data_sent all zero (vl_bit=0, vl_seq=0, vl_data=0), internal seq=0, sent_count=0, busy=0.
- in_ready is 0 while reset is high. It is 1 on the first cycle after reset.
- in_ready = !full, combinational from registered FIFO occupancy.
- No push when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle are allowed when not full. Occupancy is unchanged in that case.
- Emit condition: enable && !empty && (state==IDLE || (state==HOLD && gap_cnt==0)).
- On emit, at the clock edge:
  - data_sent.vl_data <= FIFO head
  - data_sent.vl_seq <= seq
  - data_sent.vl_bit <= ~vl_bit
  - head is popped
  - seq <= seq+1, wrapping 255->0
  - sent_count increments unless already saturated
  - state <= HOLD, gap_cnt <= GAP
- All data_sent fields change on the same edge. No partial updates.
- HOLD state:
  - gap_cnt decrements each edge while greater than 0.
  - When gap_cnt==0 and no emit occurs, state <= IDLE.
- Consecutive emissions are at least GAP+1 clock edges apart. With GAP=0 and enable held, one record is emitted per cycle.
- Latency: a word accepted at edge t, into an empty FIFO with the block IDLE and enable=1, appears on data_sent at edge t+1.
- enable=0 blocks new emissions only. The gap counter keeps running and the FIFO keeps filling. When enable rises again, emission follows the same emit rule, with no extra delay.
- busy = !empty || (state==HOLD && gap_cnt!=0).
- Reset mid-operation: all state clears on that edge. If vl_bit was 1, its return to 0 is a visible toggle. Consumers must qualify it with reset.
- Data ordering: strictly FIFO. No record is dropped or duplicated.

Decomposition:
- common_vl_pack (shared) holds typedef vl_rec with fields, in this order:
  - vl_bit: bit, event toggle
  - vl_seq: 8-bit sequence number
  - vl_data: VL_DATA_W bits
- common_vl_pack also holds localparam VL_DATA_W=32 and the state enum vl_tx_state_e {IDLE, HOLD}.
- One sub-module: vl_sync_fifo. It has parameters WIDTH and DEPTH and ports push, pop, wdata, rdata, full, empty. rdata shows the head combinationally. Pointers carry an extra wrap bit so full and empty can be distinguished.
- vl_rec_sender contains the emit state machine, seq, sent_count and the data_sent register.

Test Plan:
- Reset values: hold reset 3 cycles, then release. Expect data_sent=0, sent_count=0, busy=0, in_ready=1 on the first cycle after release.
- Single record, GAP=3, enable=1: push 32'hDEADBEEF at edge t. Expect at edge t+1 data_sent = {vl_bit=1, vl_seq=0, vl_data=DEADBEEF} and sent_count=1. busy drops after 3 more edges.
- Back-to-back, GAP=3: push A, B, C on consecutive cycles. Expect emits at t+1, t+5, t+9 with vl_bit 1,0,1 and vl_seq 0,1,2, in order A,B,C.
- Backpressure, DEPTH=4, enable=0: offer 5 words. Expect 4 accepted, in_ready=0, the 5th held on the input. Raise enable: first emit on the next edge, then in_ready returns to 1 and the 5th word is accepted.
- Sequence wrap, GAP=0: stream 257 words. Expect the 256th record to carry vl_seq=255 and the 257th vl_seq=0, with vl_bit toggling every cycle.
- Reset during HOLD with 2 words queued: assert reset. Expect FIFO empty, data_sent=0 and busy=0 on the next edge. Neither queued word is ever emitted.
